// File: rtl/fw_cmd_pkg.sv
// Shared types and constants for the SW-to-FW command decoder: op codes,
// decoder FSM states, status-word bit positions and the op-strobe helper.
package fw_cmd_pkg;

  localparam int NUM_FW_MAX     = 15;
  localparam int DEC_DROP_BIT   = 15;
  localparam int DEC_BADDEV_BIT = 14;
  localparam int DEC_CNT_W      = 14;

  typedef enum logic [3:0] {
    OP_NOP              = 4'h0,
    OP_W_RESET          = 4'h1,
    OP_W_CFG_STATIC_0   = 4'h2,
    OP_R_CFG_STATIC_0   = 4'h3,
    OP_W_CFG_STATIC_1   = 4'h4,
    OP_R_CFG_STATIC_1   = 4'h5,
    OP_W_CFG_ARRAY_0    = 4'h6,
    OP_R_CFG_ARRAY_0    = 4'h7,
    OP_W_CFG_ARRAY_1    = 4'h8,
    OP_R_CFG_ARRAY_1    = 4'h9,
    OP_W_CFG_ARRAY_2    = 4'hA,
    OP_R_CFG_ARRAY_2    = 4'hB,
    OP_R_DATA_ARRAY_0   = 4'hC,
    OP_R_DATA_ARRAY_1   = 4'hD,
    OP_W_STATUS_CLEAR   = 4'hE,
    OP_W_EXECUTE        = 4'hF
  } op_code_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    STROBE  = 2'd2,
    CAPTURE = 2'd3
  } dec_state_e;

  function automatic logic [15:0] op_onehot(input op_code_e op);
    op_onehot = 16'd1 << op;
  endfunction

endpackage

// File: rtl/fw_readback_mux.sv
// Registered selection of one IP's read data and read status from the packed
// per-IP buses; the output registers load only when cap_en is high.
module fw_readback_mux
  import fw_cmd_pkg::*;
#(
  parameter int NUM_FW = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic [3:0]            sel,
  input  logic [NUM_FW*32-1:0]  data_bus,
  input  logic [NUM_FW*32-1:0]  status_bus,
  output logic [31:0]           data,
  output logic [31:0]           status
);

  logic [31:0] data_sel_s;
  logic [31:0] status_sel_s;
  logic [31:0] data_r;
  logic [31:0] status_r;

  // Pick the 32-bit slice belonging to IP index sel.
  always_comb begin
    data_sel_s   = 32'd0;
    status_sel_s = 32'd0;
    for (int k = 0; k < NUM_FW; k++) begin
      data_sel_s   = (sel == 4'(k)) ? data_bus[k*32 +: 32]   : data_sel_s;
      status_sel_s = (sel == 4'(k)) ? status_bus[k*32 +: 32] : status_sel_s;
    end
  end

  // Capture registers hold their value between captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= 32'd0;
      status_r <= 32'd0;
    end else if (cap_en) begin
      data_r   <= data_sel_s;
      status_r <= status_sel_s;
    end else begin
      data_r   <= data_r;
      status_r <= status_r;
    end
  end

  assign data   = data_r;
  assign status = status_r;

endmodule

// File: rtl/sw_to_fw_cmd_decode.sv
// SW command front-end: latches a command word, decodes dev id / op code and
// drives device enables, op strobes and readback capture for the fw_ipN blocks.
// Optional build macro SW_CMD_COUNTER_EN adds the accepted-command counter.
module sw_to_fw_cmd_decode
  import fw_cmd_pkg::*;
#(
  parameter int NUM_FW = 15
) (
  input  logic                  fw_clk,
  input  logic                  fw_rst,
  input  logic [31:0]           sw_write32_0,
  input  logic                  sw_write32_0_valid,
  input  logic [NUM_FW*32-1:0]  fw_read_data32_bus,
  input  logic [NUM_FW*32-1:0]  fw_read_status32_bus,
  output logic [NUM_FW-1:0]     fw_dev_id_enable,
  output logic [15:0]           fw_op_code_strobe,
  output logic [23:0]           sw_write24_0,
  output logic [31:0]           sw_read_data32,
  output logic [31:0]           sw_read_status32,
  output logic [15:0]           dec_status,
  output logic                  cmd_busy
);

  dec_state_e            state_r, state_s;
  logic [31:0]           cmd_r;
  logic                  busy_r;
  logic [NUM_FW-1:0]     en_r, en_onehot_s;
  logic [15:0]           strobe_r, strobe_s;
  logic [23:0]           payload_r;
  logic                  drop_r, baddev_r;
  logic [DEC_CNT_W-1:0]  cnt_s;

  op_code_e   op_s;
  logic [3:0] id_s;
  logic       id_ok_s, baddev_s, clear_s, accept_s, drop_s, cap_en_s;

  assign op_s     = op_code_e'(cmd_r[31:28]);
  assign id_s     = cmd_r[27:24];
  assign id_ok_s  = (id_s != 4'd0) && (int'(id_s) <= NUM_FW);
  assign baddev_s = int'(id_s) > NUM_FW;
  assign clear_s  = (state_r == DECODE) && (id_s == 4'd0) && (op_s == OP_W_STATUS_CLEAR);
  assign accept_s = sw_write32_0_valid && (state_r == IDLE);
  assign drop_s   = sw_write32_0_valid && (state_r != IDLE);
  assign cap_en_s = (state_r == CAPTURE) && id_ok_s;

  // FSM state register.
  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: fixed four-cycle walk once a command is accepted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = DECODE;
        end else begin
          state_s = IDLE;
        end
      end
      DECODE:  state_s = STROBE;
      STROBE:  state_s = CAPTURE;
      CAPTURE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Decode the latched word into enable / strobe patterns.
  always_comb begin
    en_onehot_s = '0;
    for (int k = 0; k < NUM_FW; k++) begin
      en_onehot_s[k] = id_ok_s && (id_s == 4'(k + 1));
    end
    if (id_ok_s && (op_s != OP_NOP)) begin
      strobe_s = op_onehot(op_s);
    end else begin
      strobe_s = 16'd0;
    end
  end

  // Command latch and registered outputs; values computed in DECODE appear in STROBE.
  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      cmd_r     <= 32'd0;
      busy_r    <= 1'b0;
      en_r      <= '0;
      strobe_r  <= 16'd0;
      payload_r <= 24'd0;
      drop_r    <= 1'b0;
      baddev_r  <= 1'b0;
    end else begin
      cmd_r    <= accept_s ? sw_write32_0 : cmd_r;
      busy_r   <= (state_s != IDLE);
      // A drop landing on the clear cycle still leaves the drop sticky set.
      drop_r   <= (drop_r && !clear_s) || drop_s;
      baddev_r <= (baddev_r && !clear_s) || ((state_r == DECODE) && baddev_s);
      if (state_r == DECODE) begin
        en_r      <= en_onehot_s;
        strobe_r  <= strobe_s;
        payload_r <= id_ok_s ? cmd_r[23:0] : payload_r;
      end else begin
        en_r      <= en_r;
        strobe_r  <= 16'd0;
        payload_r <= payload_r;
      end
    end
  end

`ifdef SW_CMD_COUNTER_EN
  logic [DEC_CNT_W-1:0] cnt_r;

  // Accepted-command counter, wraps naturally.
  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + 14'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_s = cnt_r;
`else
  assign cnt_s = 14'd0;
`endif

  fw_readback_mux #(.NUM_FW(NUM_FW)) u_readback_mux (
    .clk        (fw_clk),
    .rst        (fw_rst),
    .cap_en     (cap_en_s),
    .sel        (id_s - 4'd1),
    .data_bus   (fw_read_data32_bus),
    .status_bus (fw_read_status32_bus),
    .data       (sw_read_data32),
    .status     (sw_read_status32)
  );

  assign fw_dev_id_enable  = en_r;
  assign fw_op_code_strobe = strobe_r;
  assign sw_write24_0      = payload_r;
  assign cmd_busy          = busy_r;

  // Status word assembly from the sticky registers and counter.
  always_comb begin
    dec_status                  = 16'd0;
    dec_status[DEC_DROP_BIT]    = drop_r;
    dec_status[DEC_BADDEV_BIT]  = baddev_r;
    dec_status[DEC_CNT_W-1:0]   = cnt_s;
  end

endmodule

// File: tb/tb_sw_to_fw_cmd_decode.sv
// Directed bench for sw_to_fw_cmd_decode: one instance with 15 IPs, one with 4.
module tb_sw_to_fw_cmd_decode;

  logic          fw_clk = 1'b0;
  logic          fw_rst;
  logic [31:0]   sw_word;
  logic          sw_valid;
  logic [479:0]  a_data, a_stat;
  logic [127:0]  b_data, b_stat;

  logic [14:0]   a_en;
  logic [3:0]    b_en;
  logic [15:0]   a_st, b_st, a_ds, b_ds;
  logic [23:0]   a_pay, b_pay;
  logic [31:0]   a_rd, a_rs, b_rd, b_rs;
  logic          a_busy, b_busy;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  logic        busy_n1, busy_n3, busy_n4;
  logic [14:0] a_en_n2;
  logic [3:0]  b_en_n2;
  logic [15:0] a_st_n2, a_st_n3, b_st_n2, b_st_n3, a_ds_n2, b_ds_n2;
  logic [23:0] a_pay_n2;
  logic [31:0] a_rd_n4, a_rs_n4, b_rd_n4;

  always #5 fw_clk = ~fw_clk;

  sw_to_fw_cmd_decode #(.NUM_FW(15)) dut (
    .fw_clk(fw_clk), .fw_rst(fw_rst), .sw_write32_0(sw_word), .sw_write32_0_valid(sw_valid),
    .fw_read_data32_bus(a_data), .fw_read_status32_bus(a_stat),
    .fw_dev_id_enable(a_en), .fw_op_code_strobe(a_st), .sw_write24_0(a_pay),
    .sw_read_data32(a_rd), .sw_read_status32(a_rs), .dec_status(a_ds), .cmd_busy(a_busy)
  );

  sw_to_fw_cmd_decode #(.NUM_FW(4)) dut4 (
    .fw_clk(fw_clk), .fw_rst(fw_rst), .sw_write32_0(sw_word), .sw_write32_0_valid(sw_valid),
    .fw_read_data32_bus(b_data), .fw_read_status32_bus(b_stat),
    .fw_dev_id_enable(b_en), .fw_op_code_strobe(b_st), .sw_write24_0(b_pay),
    .sw_read_data32(b_rd), .sw_read_status32(b_rs), .dec_status(b_ds), .cmd_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [13:0] cnt_view(input int n);
`ifdef SW_CMD_COUNTER_EN
    return 14'(n % 16384);
`else
    return 14'd0;
`endif
  endfunction

  function automatic logic [31:0] ds_exp(input logic drop, input logic bad, input int n);
    return {16'd0, drop, bad, cnt_view(n)};
  endfunction

  task automatic tick();
    @(posedge fw_clk);
    #1;
  endtask

  // Issue one command in the current (idle) cycle N and snapshot N+1..N+4.
  task automatic run_cmd(input logic [31:0] w);
    sw_word = w;
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    busy_n1 = a_busy;
    tick();
    a_en_n2 = a_en; a_st_n2 = a_st; a_pay_n2 = a_pay; a_ds_n2 = a_ds;
    b_en_n2 = b_en; b_st_n2 = b_st; b_ds_n2 = b_ds;
    tick();
    a_st_n3 = a_st; b_st_n3 = b_st; busy_n3 = a_busy;
    tick();
    a_rd_n4 = a_rd; a_rs_n4 = a_rs; b_rd_n4 = b_rd; busy_n4 = a_busy;
  endtask

  initial begin
    int n_str;
    int n_loop;
    logic [15:0] s2;
    logic [14:0] en2, en4;
    logic [31:0] ds3, rd4;
    logic busy4, busy5;

    for (int k = 0; k < 15; k++) begin
      a_data[k*32 +: 32] = (k == 0) ? 32'h1234_5678 : (32'hD000_0000 | 32'(k));
      a_stat[k*32 +: 32] = 32'h5000_0000 | 32'(k);
    end
    b_data = a_data[127:0];
    b_stat = a_stat[127:0];
    fw_rst = 1'b1;
    sw_valid = 1'b0;
    sw_word = 32'd0;
    repeat (3) tick();
    chk("rst_en", {17'd0, a_en}, 32'd0);
    chk("rst_strobe", {16'd0, a_st}, 32'd0);
    chk("rst_payload", {8'd0, a_pay}, 32'd0);
    chk("rst_rdata", a_rd, 32'd0);
    chk("rst_rstatus", a_rs, 32'd0);
    chk("rst_dec_status", {16'd0, a_ds}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_b_dec_status", {16'd0, b_ds}, 32'd0);
    fw_rst = 1'b0;
    tick();

    // op 3 to dev 1
    run_cmd(32'h3100_ABCD); exp_cnt++;
    chk("c1_busy_n1", {31'd0, busy_n1}, 32'd1);
    chk("c1_en", {17'd0, a_en_n2}, 32'h0001);
    chk("c1_strobe", {16'd0, a_st_n2}, 32'h0008);
    chk("c1_strobe_n3", {16'd0, a_st_n3}, 32'h0);
    chk("c1_payload", {8'd0, a_pay_n2}, 32'h00AB_CD);
    chk("c1_ds", {16'd0, a_ds_n2}, ds_exp(1'b0, 1'b0, exp_cnt));
    chk("c1_busy_n3", {31'd0, busy_n3}, 32'd1);
    chk("c1_rdata", a_rd_n4, 32'h1234_5678);
    chk("c1_rstatus", a_rs_n4, 32'h5000_0000);
    chk("c1_busy_n4", {31'd0, busy_n4}, 32'd0);
    chk("c1_b_rdata", b_rd_n4, 32'h1234_5678);

    // op F to dev 15: valid for 15 IPs, bad dev for 4 IPs
    run_cmd(32'hFF00_0000); exp_cnt++;
    chk("c2_en", {17'd0, a_en_n2}, 32'h4000);
    chk("c2_strobe", {16'd0, a_st_n2}, 32'h8000);
    chk("c2_strobe_n3", {16'd0, a_st_n3}, 32'h0);
    chk("c2_ds", {16'd0, a_ds_n2}, ds_exp(1'b0, 1'b0, exp_cnt));
    chk("c2_rdata", a_rd_n4, 32'hD000_000E);
    chk("c2_rstatus", a_rs_n4, 32'h5000_000E);
    chk("c2_b_en", {28'd0, b_en_n2}, 32'h0);
    chk("c2_b_strobe", {16'd0, b_st_n2 | b_st_n3}, 32'h0);
    chk("c2_b_baddev", {16'd0, b_ds_n2}, ds_exp(1'b0, 1'b1, exp_cnt));
    chk("c2_b_rdata_held", b_rd_n4, 32'h1234_5678);

    // dev 0 status clear
    run_cmd(32'hE000_0000); exp_cnt++;
    chk("c3_en", {17'd0, a_en_n2}, 32'h0);
    chk("c3_strobe", {16'd0, a_st_n2 | a_st_n3}, 32'h0);
    chk("c3_payload_held", {8'd0, a_pay_n2}, 32'h0);
    chk("c3_rdata_held", a_rd_n4, 32'hD000_000E);
    chk("c3_b_cleared", {16'd0, b_ds_n2}, ds_exp(1'b0, 1'b0, exp_cnt));
    chk("c3_b_strobe", {16'd0, b_st_n2 | b_st_n3}, 32'h0);

    // NOP to dev 2: enable and capture but no strobe
    run_cmd(32'h0200_1111); exp_cnt++;
    chk("c4_en", {17'd0, a_en_n2}, 32'h0002);
    chk("c4_strobe", {16'd0, a_st_n2 | a_st_n3}, 32'h0);
    chk("c4_payload", {8'd0, a_pay_n2}, 32'h0011_11);
    chk("c4_rdata", a_rd_n4, 32'hD000_0001);
    chk("c4_b_rdata", b_rd_n4, 32'hD000_0001);

    // second valid at N+2 is dropped
    n_str = 0;
    sw_word = 32'h5300_0042; sw_valid = 1'b1;
    tick(); sw_valid = 1'b0; n_str += (a_st != 16'd0) ? 1 : 0;
    tick(); s2 = a_st; en2 = a_en; n_str += (a_st != 16'd0) ? 1 : 0;
    sw_word = 32'h7400_0000; sw_valid = 1'b1;
    tick(); sw_valid = 1'b0; ds3 = {16'd0, a_ds}; n_str += (a_st != 16'd0) ? 1 : 0;
    tick(); rd4 = a_rd; busy4 = a_busy; en4 = a_en; n_str += (a_st != 16'd0) ? 1 : 0;
    tick(); busy5 = a_busy; n_str += (a_st != 16'd0) ? 1 : 0;
    exp_cnt++;
    chk("d_strobe", {16'd0, s2}, 32'h0020);
    chk("d_en", {17'd0, en2}, 32'h0004);
    chk("d_drop_sticky", ds3, ds_exp(1'b1, 1'b0, exp_cnt));
    chk("d_rdata", rd4, 32'hD000_0002);
    chk("d_en_held", {17'd0, en4}, 32'h0004);
    chk("d_busy_n4", {31'd0, busy4}, 32'd0);
    chk("d_busy_n5", {31'd0, busy5}, 32'd0);
    chk("d_strobe_count", 32'(n_str), 32'd1);

    // back-to-back: second command presented in the N+4 cycle
    run_cmd(32'h1500_0000); exp_cnt++;
    chk("b1_en", {17'd0, a_en_n2}, 32'h0010);
    chk("b1_strobe", {16'd0, a_st_n2}, 32'h0002);
    chk("b1_rdata", a_rd_n4, 32'hD000_0004);
    run_cmd(32'h9600_0000); exp_cnt++;
    chk("b2_busy_n1", {31'd0, busy_n1}, 32'd1);
    chk("b2_en", {17'd0, a_en_n2}, 32'h0020);
    chk("b2_strobe", {16'd0, a_st_n2}, 32'h0200);
    chk("b2_ds", {16'd0, a_ds_n2}, ds_exp(1'b1, 1'b0, exp_cnt));
    chk("b2_rdata", a_rd_n4, 32'hD000_0005);

    // reset mid-command
    sw_word = 32'h3700_0000; sw_valid = 1'b1;
    tick(); sw_valid = 1'b0; fw_rst = 1'b1;
    tick();
    chk("r_strobe_n2", {16'd0, a_st}, 32'h0);
    chk("r_en_n2", {17'd0, a_en}, 32'h0);
    tick(); fw_rst = 1'b0;
    exp_cnt = 0;
    chk("r_strobe_n3", {16'd0, a_st}, 32'h0);
    chk("r_en_n3", {17'd0, a_en}, 32'h0);
    chk("r_payload", {8'd0, a_pay}, 32'h0);
    chk("r_rdata", a_rd, 32'h0);
    chk("r_rstatus", a_rs, 32'h0);
    chk("r_ds", {16'd0, a_ds}, 32'h0);
    chk("r_busy", {31'd0, a_busy}, 32'h0);
    run_cmd(32'h3100_ABCD); exp_cnt++;
    chk("r2_busy_n1", {31'd0, busy_n1}, 32'd1);
    chk("r2_en", {17'd0, a_en_n2}, 32'h0001);
    chk("r2_strobe", {16'd0, a_st_n2}, 32'h0008);
    chk("r2_ds", {16'd0, a_ds_n2}, ds_exp(1'b0, 1'b0, exp_cnt));
    chk("r2_rdata", a_rd_n4, 32'h1234_5678);

    // counter wrap (or stays zero when not built)
`ifdef SW_CMD_COUNTER_EN
    n_loop = 16384 - exp_cnt;
`else
    n_loop = 8;
`endif
    for (int i = 0; i < n_loop; i++) begin
      run_cmd(32'h0000_0000); exp_cnt++;
    end
    chk("cnt_end", {18'd0, a_ds[13:0]}, {18'd0, cnt_view(exp_cnt)});
    run_cmd(32'h0000_0000); exp_cnt++;
    chk("cnt_after", {16'd0, a_ds_n2}, ds_exp(1'b0, 1'b0, exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_to_fw_cmd_decode.md
# sw_to_fw_cmd_decode

Command front-end between the SW register interface and the per-IP firmware blocks (fw_ip1..fw_ip15). It latches a 32-bit SW command word, decodes the device id and op code in byte 3, and drives one-hot device enables plus single-cycle op-code strobes to the selected IP. It then captures that IP's read data and read status for SW readback. It is the stage directly upstream of every fw_ipN block.

## Interface
- NUM_FW, 15: number of connected FW IPs, legal range 1..15.
- fw_clk  in  1  FW clock; all logic on rising edge.
- fw_rst  in  1  synchronous, active-high reset.
- sw_write32_0  in  32  command word: [31:28] op code, [27:24] dev id, [23:0] payload.
- sw_write32_0_valid  in  1  one-cycle pulse when SW writes sw_write32_0.
- fw_read_data32_bus  in  NUM_FW*32  read data from each IP; IP k (id k+1) on bits [32k+31:32k].
- fw_read_status32_bus  in  NUM_FW*32  read status from each IP, same packing.
- fw_dev_id_enable  out  NUM_FW  one-hot enable; bit k set for dev id k+1.
- fw_op_code_strobe  out  16  one-hot op strobe; bit n set for op code n, bit 0 never set.
- sw_write24_0  out  24  payload of the last accepted command, held.
- sw_read_data32  out  32  captured read data of the addressed IP.
- sw_read_status32  out  32  captured read status of the addressed IP.
- dec_status  out  16  [15] drop sticky, [14] bad-dev sticky, [13:0] accepted-command counter.
- cmd_busy  out  1  high while a command is in flight.

## Operation
- Op codes: 0 NOP, 1 W_RESET, 2/3 W/R_CFG_STATIC_0, 4/5 W/R_CFG_STATIC_1, 6/7 W/R_CFG_ARRAY_0, 8/9 W/R_CFG_ARRAY_1, A/B W/R_CFG_ARRAY_2, C R_DATA_ARRAY_0, D R_DATA_ARRAY_1, E W_STATUS_CLEAR, F W_EXECUTE.
- FSM states:
  - IDLE: on valid, latch the word, go to DECODE.
  - DECODE: go to STROBE.
  - STROBE: drive strobes and enables, go to CAPTURE.
  - CAPTURE: capture the selected IP's data and status, go to IDLE.
- Valid dev id 1..NUM_FW in STROBE:
  - fw_dev_id_enable becomes onehot(id-1) and holds until the next accepted command.
  - fw_op_code_strobe[op] is high for exactly one cycle; sw_write24_0 updates in the same cycle.
- Dev id 0:
  - no enable and no strobe.
  - op E clears dec_status[15:14]; all other ops are no-ops. Capture registers keep their values.
- Dev id > NUM_FW: set bad-dev sticky; no enable, no strobe, no capture.
- Op 0 (NOP) to a valid id: enable updates, no strobe, capture still occurs.
- Valid while busy: the command is dropped, drop sticky is set, and the FSM is unaffected.
- Counter increments once per accepted command, whatever the id/op, and wraps 3FFF→0000.
- Reset values: all outputs 0; FSM in IDLE.

## Timing
- Cycle N: valid while IDLE.
- N+1: cmd_busy=1 (DECODE).
- N+2: strobe and enable visible (registered).
- N+3: CAPTURE; bus sampled at the N+3→N+4 edge.
- N+4: sw_read_* hold the new values, cmd_busy=0, and a new valid is accepted.
- Total latency to readback: 4 cycles. Maximum throughput: one command per 4 cycles.
- Valid in the same cycle the FSM returns to IDLE (N+4) is accepted.
- fw_rst asserted in any state: next cycle is IDLE with all outputs 0, and any pending strobe is suppressed.
- fw_rst has priority over a simultaneous valid.

## Configuration
- SW_CMD_COUNTER_EN defined: 14-bit accepted-command counter present in dec_status[13:0].
- SW_CMD_COUNTER_EN undefined: counter is not built and dec_status[13:0] reads 0. The sticky bits are unaffected.

## Structure
- Package fw_cmd_pkg holds:
  - op_code_e (4-bit enum with the values above);
  - dec_state_e (IDLE, DECODE, STROBE, CAPTURE);
  - NUM_FW_MAX=15 and the dec_status bit positions.
- Sub-module fw_readback_mux: parameterised NUM_FW, registered select of the data and status buses with a capture-enable. It is instantiated once.

## Test plan
- Reset, then valid with word 0x3_1_00ABCD and IP0 data 0x12345678 → N+2: enable=0x0001, strobe=0x0008, sw_write24_0=0x00ABCD; N+4: sw_read_data32=0x12345678, busy=0.
- Word 0xF_F_000000 with NUM_FW=15 → enable bit 14, strobe bit 15 for one cycle; counter=1.
- Word with dev id 0 and op E after a bad-dev word (dev id > NUM_FW, e.g. id 15 with NUM_FW=4) → bad-dev sticky set, then cleared; no strobe either time.
- Second valid at N+2 → dropped; drop sticky=1; one strobe only; counter increments by 1.
- fw_rst at N+2 → strobe never asserted, all outputs 0 at N+3; next command accepted normally.
- With SW_CMD_COUNTER_EN: 16384 commands → counter wraps to 0. Without it → dec_status[13:0]=0 throughout.
